mask_compactor: RTL
===================

MASK_COMPACTOR -- requirements
Module: mask_compactor

Interface
REQ-001 Parameter LANES, default 128: number of input lanes per vector.
REQ-002 Parameter DATA_W, default 8: bit width of each lane element.
REQ-003 Parameter OUT_LANES, default 8: elements per output beat; SHALL divide LANES.
REQ-004 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-006 Port in_valid, input, 1: the input vector is valid.
REQ-007 Port in_ready, output, 1: the block accepts a vector this cycle.
REQ-008 Port in_data, input, LANES*DATA_W: lane i occupies bits [i*DATA_W +: DATA_W].
REQ-009 Port in_mask, input, LANES: 1 = keep lane (non-redundant), 0 = drop.
REQ-010 Port in_psum, input, LANES*7: exclusive prefix count of in_mask, driven by LFPrefixSum128; lane i is at [i*7 +: 7].
REQ-011 Port out_valid, output, 1: an output beat is valid.
REQ-012 Port out_ready, input, 1: the downstream stage accepts the beat.
REQ-013 Port out_data, output, OUT_LANES*DATA_W: compacted elements, slot 0 in the lowest bits.
REQ-014 Port out_keep, output, OUT_LANES: per-slot valid flags, contiguous from slot 0.
REQ-015 Port out_last, output, 1: final beat of the current vector.
REQ-016 Port out_count, output, 8: total kept elements of the current vector (0..128), stable for all beats of that vector.

Function
REQ-017 in_psum[i] SHALL equal popcount(in_mask[i-1:0]); the block trusts in_psum and does not re-check it.
REQ-018 Vector acceptance SHALL occur on in_valid & in_ready.
REQ-019 On acceptance, element i with in_mask[i]=1 SHALL be written to compacted slot in_psum[i] of a registered buffer; unused slots SHALL be zero.
REQ-020 On acceptance, count SHALL be registered as in_psum[LANES-1] + in_mask[LANES-1], computed 8 bits wide.
REQ-021 FSM states: IDLE and EMIT.
- IDLE -> EMIT on acceptance.
- EMIT -> IDLE on the last-beat handshake with no new acceptance.
- EMIT -> EMIT on the last-beat handshake with a simultaneous acceptance.
REQ-022 in_ready SHALL equal (state==IDLE) | (out_valid & out_ready & out_last), giving back-to-back vectors with no bubble.
REQ-023 out_valid SHALL be high exactly in EMIT, i.e. the first beat appears one cycle after acceptance.
REQ-024 Number of beats SHALL be max(1, ceil(count/OUT_LANES)).
REQ-025 Beat b SHALL carry buffer slots b*OUT_LANES .. b*OUT_LANES+OUT_LANES-1.
REQ-026 out_keep[k] SHALL be 1 iff b*OUT_LANES+k < count.
REQ-027 A beat counter SHALL advance only on out_valid & out_ready.
REQ-028 While out_valid & !out_ready, out_data, out_keep, out_last and out_count SHALL hold stable.
REQ-029 count==0 SHALL emit exactly one beat with out_keep=0, out_data=0 and out_last=1.
REQ-030 count==LANES SHALL emit LANES/OUT_LANES full beats in lane order.
REQ-031 in_data, in_mask and in_psum SHALL be ignored when no acceptance occurs.

Reset
REQ-032 reset_n low SHALL force state=IDLE, the beat counter to 0, count to 0, and the buffer to 0.
REQ-033 While reset_n is low, outputs SHALL be: out_valid=0, out_keep=0, out_last=0, out_data=0, out_count=0, in_ready=1.
REQ-034 Reset asserted mid-vector SHALL discard the remaining beats; the first vector accepted after reset SHALL be emitted in full.

Structure
REQ-035 A shared package/header SHALL hold the PSUM_W=7 and CNT_W=8 constants and the IDLE/EMIT state encoding.
REQ-036 The scatter network (per-slot select of the lane where in_mask[i] & in_psum[i]==slot) SHALL be a combinational sub-module, compact_scatter; the FSM, buffer and beat counter live in mask_compactor.

Verification
REQ-037 The bench SHALL instantiate LFPrefixSum128 driving in_psum from in_mask and cover these scenarios:
- Mask 32'b00001000000010000010000000010011 replicated x4 with data[i]=i -> count=24, 3 full beats, last beat out_keep=8'hFF, data equal to the set-bit indices in ascending order.
- Mask 32'b00100001000100100100010100000000 x4 -> count=28, 4 beats, last beat out_keep=8'h0F, out_last only on beat 4.
- Mask 32'b01001011101000100100011101011101 x4 -> count=64, 8 full beats; then a second vector presented during the last beat is accepted with zero bubble cycles.
- Mask all-zero -> exactly one beat with out_keep=0, out_last=1, out_count=0; mask all-ones -> 16 beats with data 0..127.
- out_ready toggled pseudo-randomly on the 28-count case -> outputs stable while stalled, no beat lost or duplicated.
- reset_n pulsed low during beat 2 of the 24-count case -> outputs zero immediately; the next vector is emitted correctly.

Source files
------------

// File: rtl/mask_compactor_pkg.sv
// Shared constants and FSM encoding for the mask compactor.
package mask_compactor_pkg;
    localparam int unsigned PSUM_W = 7;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;
endpackage

// File: rtl/mask_compactor_if.sv
// Vector-in / beat-out handshake bundle for the mask compactor.
interface mask_compactor_if #(
    parameter int unsigned LANES     = 128,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned OUT_LANES = 8
);
    import mask_compactor_pkg::*;

    logic                              in_valid;
    logic                              in_ready;
    logic [LANES*DATA_W-1:0]           in_data;
    logic [LANES-1:0]                  in_mask;
    logic [LANES*PSUM_W-1:0]           in_psum;
    logic                              out_valid;
    logic                              out_ready;
    logic [OUT_LANES*DATA_W-1:0]       out_data;
    logic [OUT_LANES-1:0]              out_keep;
    logic                              out_last;
    logic [CNT_W-1:0]                  out_count;

    modport master (
        output in_valid, in_data, in_mask, in_psum, out_ready,
        input  in_ready, out_valid, out_data, out_keep, out_last, out_count
    );

    modport slave (
        input  in_valid, in_data, in_mask, in_psum, out_ready,
        output in_ready, out_valid, out_data, out_keep, out_last, out_count
    );
endinterface

// File: rtl/LFPrefixSum128.sv
// Exclusive prefix popcount over a 128-bit mask, one PSUM_W field per lane.
module LFPrefixSum128
    import mask_compactor_pkg::*;
(
    input  logic [127:0]          mask,
    output logic [128*PSUM_W-1:0] psum
);
    logic [PSUM_W-1:0] acc;

    always_comb begin
        acc  = '0;
        psum = '0;
        for (int unsigned i = 0; i < 128; i++) begin
            psum[i*PSUM_W +: PSUM_W] = acc;
            acc = acc + PSUM_W'(mask[i]);
        end
    end
endmodule

// File: rtl/compact_scatter.sv
// Combinational scatter: slot s takes the kept lane whose prefix count equals s.
module compact_scatter
    import mask_compactor_pkg::*;
#(
    parameter int unsigned LANES  = 128,
    parameter int unsigned DATA_W = 8
) (
    input  logic [LANES*DATA_W-1:0] data,
    input  logic [LANES-1:0]        mask,
    input  logic [LANES*PSUM_W-1:0] psum,
    output logic [LANES*DATA_W-1:0] slots
);
    // A lane's prefix count never exceeds its index, so only lanes i >= s can land in slot s.
    always_comb begin
        slots = '0;
        for (int unsigned s = 0; s < LANES; s++) begin
            for (int unsigned i = s; i < LANES; i++) begin
                if (mask[i] && (psum[i*PSUM_W +: PSUM_W] == PSUM_W'(s))) begin
                    slots[s*DATA_W +: DATA_W] |= data[i*DATA_W +: DATA_W];
                end
            end
        end
    end
endmodule

// File: rtl/mask_compactor.sv
// Captures a masked vector into a compacted buffer and streams it out in OUT_LANES-wide beats.
module mask_compactor
    import mask_compactor_pkg::*;
#(
    parameter int unsigned LANES     = 128,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned OUT_LANES = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    mask_compactor_if.slave   bus
);
    localparam int unsigned BEATS     = LANES / OUT_LANES;
    localparam int unsigned BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned SLOT_W    = CNT_W + 1;
    localparam int unsigned BEAT_BITS = OUT_LANES * DATA_W;

    state_t                  state;
    state_t                  state_next;
    logic [BEAT_W-1:0]       beat;
    logic [CNT_W-1:0]        count;
    logic [LANES*DATA_W-1:0] buffer;
    logic [LANES*DATA_W-1:0] slots;
    logic [SLOT_W-1:0]       base;
    logic [SLOT_W-1:0]       count_ext;
    logic                    last;
    logic                    accept;

    compact_scatter #(
        .LANES  (LANES),
        .DATA_W (DATA_W)
    ) u_scatter (
        .data  (bus.in_data),
        .mask  (bus.in_mask),
        .psum  (bus.in_psum),
        .slots (slots)
    );

    // First slot of the current beat; the beat is last once its window reaches count.
    assign base      = SLOT_W'(32'(beat) * OUT_LANES);
    assign count_ext = SLOT_W'(count);
    assign last      = (base + SLOT_W'(OUT_LANES)) >= count_ext;
    assign accept    = bus.in_valid & bus.in_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        bus.in_ready = 1'b0;
        unique case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_next = EMIT;
                end
            end
            EMIT: begin
                if (bus.out_ready && last) begin
                    bus.in_ready = 1'b1;
                    state_next   = bus.in_valid ? EMIT : IDLE;
                end
            end
        endcase
    end

    // Capture on acceptance (which also restarts the beat counter); otherwise step per handshake.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            beat   <= '0;
            count  <= '0;
            buffer <= '0;
        end else if (accept) begin
            beat   <= '0;
            count  <= CNT_W'(bus.in_psum[(LANES-1)*PSUM_W +: PSUM_W]) + CNT_W'(bus.in_mask[LANES-1]);
            buffer <= slots;
        end else if (bus.out_valid && bus.out_ready) begin
            beat <= last ? '0 : beat + BEAT_W'(1);
        end
    end

    assign bus.out_valid = (state == EMIT);
    assign bus.out_last  = bus.out_valid & last;
    assign bus.out_count = count;
    assign bus.out_data  = buffer[32'(beat)*BEAT_BITS +: BEAT_BITS];

    always_comb begin
        bus.out_keep = '0;
        for (int unsigned k = 0; k < OUT_LANES; k++) begin
            bus.out_keep[k] = bus.out_valid && ((base + SLOT_W'(k)) < count_ext);
        end
    end
endmodule
